// File: rtl/cnn_result_collector_if.sv
// Stream-out bundle of the CNN result collector: one captured cell value per beat,
// valid/ready handshake, with cell index and last-beat marker.
interface cnn_result_collector_if #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned N_CELLS = 16
);
  localparam int unsigned IdxW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IdxW-1:0]   out_idx;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/cnn_result_collector.sv
// Result collector for the 4x4 cellular-network array. After start it waits for all cell
// outputs to hold still for STABLE_CYCLES cycles, snapshots them and streams one cell per beat.
// Optional settle timeout is enabled by defining CNN_COLLECT_TIMEOUT_EN.
module cnn_result_collector #(
  parameter int unsigned DATA_W        = 9,
  parameter int unsigned N_CELLS       = 16,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned MAX_WAIT      = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W*N_CELLS-1:0] y_flat,
  cnn_result_collector_if.master    out_if,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout
);
  localparam int unsigned FlatW = DATA_W * N_CELLS;
  localparam int unsigned IdxW  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int unsigned StW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_CELLS - 1);
  localparam logic [StW-1:0]  StableLast = StW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES == 0 || MAX_WAIT == 0) begin : g_bad_cfg
    $error("cnn_result_collector: STABLE_CYCLES and MAX_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StStream} state_e;

  state_e           state_q, state_d;
  logic [FlatW-1:0] y_prev_q, y_prev_d;
  logic [FlatW-1:0] cap_q, cap_d;
  logic [StW-1:0]   stable_cnt_q, stable_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             same, converged, hs;

`ifdef CNN_COLLECT_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             expired;

  assign expired = (wait_cnt_q == WaitLast);
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign same      = (y_flat == y_prev_q);
  assign converged = same && (stable_cnt_q == StableLast);
  assign hs        = valid_q && out_if.out_ready;

  // Next-state: convergence watch, capture, and beat sequencing.
  always_comb begin
    state_d      = state_q;
    y_prev_d     = y_prev_q;
    cap_d        = cap_q;
    stable_cnt_d = stable_cnt_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
`ifdef CNN_COLLECT_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StSettle;
          y_prev_d     = y_flat;
          stable_cnt_d = '0;
`ifdef CNN_COLLECT_TIMEOUT_EN
          wait_cnt_d   = '0;
          timeout_d    = 1'b0;
`endif
        end
      end
      StSettle: begin
        y_prev_d     = y_flat;
        stable_cnt_d = same ? stable_cnt_q + StW'(1) : '0;
`ifdef CNN_COLLECT_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q + WaitW'(1);
`endif
        // Convergence takes priority over an expiring timeout in the same cycle.
        if (converged) begin
          cap_d   = y_flat;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = StStream;
        end
`ifdef CNN_COLLECT_TIMEOUT_EN
        else if (expired) begin
          cap_d     = y_flat;
          idx_d     = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StStream;
        end
`endif
      end
      StStream: begin
        if (hs) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      y_prev_q     <= '0;
      cap_q        <= '0;
      stable_cnt_q <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
`ifdef CNN_COLLECT_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      y_prev_q     <= y_prev_d;
      cap_q        <= cap_d;
      stable_cnt_q <= stable_cnt_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
`ifdef CNN_COLLECT_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = valid_q ? cap_q[idx_q*DATA_W +: DATA_W] : '0;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = valid_q && (idx_q == LastIdx);
  assign busy             = (state_q != StIdle);
  assign done             = done_q;
endmodule

// File: tb/tb_cnn_result_collector.sv
// Bench for cnn_result_collector: directed and randomized runs checked against a
// sequence-level model of convergence/timeout capture and the expected beat stream.
module tb_cnn_result_collector;
  localparam int DW = 9;
  localparam int NC = 16;
  localparam int SC = 8;
  localparam int MW = 32;
  localparam int FW = DW * NC;
  localparam int MAXLEN = 64;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [FW-1:0] y_flat;
  logic          busy;
  logic          done;
  logic          timeout;

  int checks;
  int errors;

  logic [FW-1:0] y_seq [0:MAXLEN];

  cnn_result_collector_if #(.DATA_W(DW), .N_CELLS(NC)) oif ();

  cnn_result_collector #(
    .DATA_W       (DW),
    .N_CELLS      (NC),
    .STABLE_CYCLES(SC),
    .MAX_WAIT     (MW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .y_flat (y_flat),
    .out_if (oif),
    .busy   (busy),
    .done   (done),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] set_cell(input logic [FW-1:0] v, input int i,
                                             input logic [DW-1:0] x);
    v[i*DW +: DW] = x;
    return v;
  endfunction

  function automatic logic [DW-1:0] get_cell(input logic [FW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [FW-1:0] rand_flat();
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v = set_cell(v, i, DW'($urandom));
    return v;
  endfunction

  task automatic fill_const(input logic [FW-1:0] v);
    for (int i = 0; i <= MAXLEN; i++) y_seq[i] = v;
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // abort_after >= 0: assert reset once that many beats were accepted.
  task automatic run(input int rmode, input bit noise, input int abort_after, input string tag);
    int            c;
    bit            to;
    logic [FW-1:0] cap;
    int            idx;
    int            s;
    bit            r;
    c = -1;
    to = 1'b0;
    // Capture happens at the first cycle whose sample matches the previous SC samples.
    for (int k = SC; k <= MAXLEN && c < 0; k++) begin
      bit eq;
      eq = 1'b1;
      for (int j = k - SC; j < k; j++) if (y_seq[j] !== y_seq[k]) eq = 1'b0;
      if (eq) c = k;
    end
`ifdef CNN_COLLECT_TIMEOUT_EN
    if (c < 0 || c > MW) begin
      c = MW;
      to = 1'b1;
    end
`endif
    start = 1'b1;
    y_flat = y_seq[0];
    oif.out_ready = 1'($urandom);
    tick();
    start = 1'b0;
    if (c < 0) begin
      for (int i = 1; i <= MAXLEN; i++) begin
        y_flat = y_seq[i];
        chk({tag, "_novalid"}, 32'(oif.out_valid), 0);
        chk({tag, "_nobusy"}, 32'(busy), 1);
        tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      return;
    end
    for (int i = 1; i <= c; i++) begin
      y_flat = y_seq[i];
      start = noise ? 1'($urandom) : 1'b0;
      chk({tag, "_settle_busy"}, 32'(busy), 1);
      chk({tag, "_settle_valid"}, 32'(oif.out_valid), 0);
      chk({tag, "_settle_done"}, 32'(done), 0);
      chk({tag, "_settle_tmo"}, 32'(timeout), 0);
      tick();
    end
    cap = y_seq[c];
    idx = 0;
    s = 0;
    while (idx < NC) begin
      y_flat = rand_flat();
      start = noise ? 1'($urandom) : 1'b0;
      case (rmode)
        0: r = 1'b1;
        1: r = (s % 3 == 0);
        default: r = ($urandom_range(3) != 0);
      endcase
      oif.out_ready = r;
      if (abort_after >= 0 && idx == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 32'(oif.out_valid), 0);
        chk({tag, "_rst_data"}, 32'(oif.out_data), 0);
        chk({tag, "_rst_idx"}, 32'(oif.out_idx), 0);
        chk({tag, "_rst_last"}, 32'(oif.out_last), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        chk({tag, "_rst_done"}, 32'(done), 0);
        chk({tag, "_rst_tmo"}, 32'(timeout), 0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      chk({tag, "_valid"}, 32'(oif.out_valid), 1);
      chk({tag, "_idx"}, 32'(oif.out_idx), 32'(idx));
      chk({tag, "_data"}, 32'(oif.out_data), 32'(get_cell(cap, idx)));
      chk({tag, "_last"}, 32'(oif.out_last), 32'(idx == NC - 1));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_tmo"}, 32'(timeout), 32'(to));
      if (r) idx++;
      s++;
      tick();
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_valid"}, 32'(oif.out_valid), 0);
    chk({tag, "_done_last"}, 32'(oif.out_last), 0);
    chk({tag, "_done_tmo"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    logic [FW-1:0] v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    y_flat = '0;
    oif.out_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(oif.out_valid), 0);
    chk("reset_data", 32'(oif.out_data), 0);
    chk("reset_idx", 32'(oif.out_idx), 0);
    chk("reset_last", 32'(oif.out_last), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_tmo", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();

    // Yk = k, always ready: first valid in cycle SC+1.
    v = '0;
    for (int k = 0; k < NC; k++) v = set_cell(v, k, DW'(k + 1));
    fill_const(v);
    run(0, 1'b0, -1, "const");

    // Y5 toggles 0x0FF/0x100 for 5 cycles after start, then everything holds.
    v = rand_flat();
    for (int i = 0; i <= MAXLEN; i++) begin
      int t;
      t = (i > 5) ? 5 : i;
      y_seq[i] = set_cell(v, 4, (t % 2 == 1) ? 9'h100 : 9'h0FF);
    end
    run(0, 1'b0, -1, "settle");

    fill_const(rand_flat());
    run(1, 1'b0, -1, "bp");

    v = rand_flat();
    v = set_cell(v, 0, 9'h1FF);
    v = set_cell(v, NC - 1, 9'h100);
    fill_const(v);
    run(2, 1'b0, -1, "neg");

    fill_const(rand_flat());
    run(0, 1'b0, 7, "rstmid");
    fill_const(rand_flat());
    run(0, 1'b0, -1, "postrst");

    for (int n = 0; n < 5; n++) begin
      int nchg;
      v = rand_flat();
      nchg = $urandom_range(12);
      for (int i = 0; i <= MAXLEN; i++) begin
        if (i <= nchg && $urandom_range(1) == 1) v = set_cell(v, $urandom_range(NC - 1), DW'($urandom));
        y_seq[i] = v;
      end
      run(2, 1'b1, -1, "rnd");
    end

    // Y1 increments every cycle: never converges.
    v = rand_flat();
    for (int i = 0; i <= MAXLEN; i++) y_seq[i] = set_cell(v, 0, DW'(i));
    run(0, 1'b0, -1, "tmo");

    fill_const(rand_flat());
    run(1, 1'b0, -1, "aftertmo");
    tick();
    chk("final_done_low", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
